// File: rtl/cr_xp10_decomp_be_ob_arb_pkg.sv
// Shared types for the XP10 decompressor back-end output arbiter.
// Optional statistics are enabled with CR_XP10_DECOMP_BE_OB_STATS_EN.
package cr_xp10_decomp_be_ob_arb_pkg;

  localparam int unsigned BE_OB_ORD_DEPTH     = 16;
  localparam int unsigned BE_OB_ORD_AFULL_LVL = 12;

  typedef enum logic [1:0] {IDLE, PT_XFER, LZ_XFER} be_ob_arb_st_e;

  typedef enum logic {BE_SRC_PT = 1'b0, BE_SRC_LZ = 1'b1} be_ob_src_e;

  typedef struct packed {
    logic        insert;
    logic [7:0]  ordern;
    logic [3:0]  typen;
    logic        sot;
    logic        eot;
    logic        tlast;
    logic [1:0]  tid;
    logic [7:0]  tstrb;
    logic [63:0] tdata;
  } tlvp_if_bus_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_be_ob_arb_if.sv
// Bus bundle of the back-end output arbiter: order push, two TLV sources, output port.
// Statistic outputs exist only with CR_XP10_DECOMP_BE_OB_STATS_EN.
interface cr_xp10_decomp_be_ob_arb_if;
  import cr_xp10_decomp_be_ob_arb_pkg::*;

  logic         ord_wr;
  logic         ord_src;
  logic         ord_afull;
  logic         ord_overflow;
  logic         pt_empty;
  tlvp_if_bus_t pt_tlv;
  logic         pt_rd;
  logic         lz_empty;
  tlvp_if_bus_t lz_tlv;
  logic         lz_rd;
  logic         ob_afull;
  logic         ob_wr;
  tlvp_if_bus_t ob_tlv;
  logic         busy;
`ifdef CR_XP10_DECOMP_BE_OB_STATS_EN
  logic [31:0]  stat_pt_tlvs;
  logic [31:0]  stat_lz_tlvs;
  logic [31:0]  stat_stall_cyc;
`endif

  modport slave (
    input  ord_wr, ord_src, pt_empty, pt_tlv, lz_empty, lz_tlv, ob_afull,
    output ord_afull, ord_overflow, pt_rd, lz_rd, ob_wr, ob_tlv, busy
`ifdef CR_XP10_DECOMP_BE_OB_STATS_EN
    , output stat_pt_tlvs, stat_lz_tlvs, stat_stall_cyc
`endif
  );

  modport master (
    output ord_wr, ord_src, pt_empty, pt_tlv, lz_empty, lz_tlv, ob_afull,
    input  ord_afull, ord_overflow, pt_rd, lz_rd, ob_wr, ob_tlv, busy
`ifdef CR_XP10_DECOMP_BE_OB_STATS_EN
    , input stat_pt_tlvs, stat_lz_tlvs, stat_stall_cyc
`endif
  );

endinterface

// File: rtl/cr_xp10_decomp_be_ob_stats.sv
// Saturating TLV and stall counters for the back-end output arbiter
// (instantiated only with CR_XP10_DECOMP_BE_OB_STATS_EN).
module cr_xp10_decomp_be_ob_stats
  import cr_xp10_decomp_be_ob_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pt_eot_i,
  input  logic        lz_eot_i,
  input  logic        stall_i,
  output logic [31:0] stat_pt_tlvs_o,
  output logic [31:0] stat_lz_tlvs_o,
  output logic [31:0] stat_stall_cyc_o
);

  logic [31:0] pt_q, lz_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q    <= '0;
      lz_q    <= '0;
      stall_q <= '0;
    end else begin
      pt_q    <= sat_inc(pt_q, pt_eot_i);
      lz_q    <= sat_inc(lz_q, lz_eot_i);
      stall_q <= sat_inc(stall_q, stall_i);
    end
  end

  assign stat_pt_tlvs_o   = pt_q;
  assign stat_lz_tlvs_o   = lz_q;
  assign stat_stall_cyc_o = stall_q;

endmodule

// File: rtl/nx_fifo.sv
// Synchronous FIFO without write-to-read bypass; a pop frees a slot for a same-cycle push.
module nx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      used_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_rd, do_wr;

  assign used_o     = wptr_q - rptr_q;
  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (used_o == (AW+1)'(DEPTH));
  assign do_rd      = rd_i && !empty_o;
  assign do_wr      = wr_i && (!full_o || do_rd);
  assign overflow_o = wr_i && !do_wr;
  assign rdata_o    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cr_xp10_decomp_be_ob_arb.sv
// XP10 back-end output scheduler: merges PT and LZ TLV FIFOs in header-parser order.
// Define CR_XP10_DECOMP_BE_OB_STATS_EN to add saturating statistic counters.
module cr_xp10_decomp_be_ob_arb
  import cr_xp10_decomp_be_ob_arb_pkg::*;
#(
  parameter int unsigned ORD_DEPTH     = BE_OB_ORD_DEPTH,
  parameter int unsigned ORD_AFULL_LVL = BE_OB_ORD_AFULL_LVL
) (
  input  logic                           clk,
  input  logic                           rst_n,
  cr_xp10_decomp_be_ob_arb_if.slave      bus_io
);

  localparam int unsigned AW = $clog2(ORD_DEPTH);
  localparam logic [AW:0] AfullLvl = ORD_AFULL_LVL[AW:0];

  be_ob_arb_st_e state_q, state_d;
  logic          ord_pop, ord_empty, ord_full, ord_ovf;
  logic [0:0]    ord_head;
  logic [AW:0]   ord_used;
  logic          pt_rd, lz_rd;
  logic          ovf_q;
  logic          ob_wr_q;
  tlvp_if_bus_t  ob_tlv_q, ob_tlv_d;

  nx_fifo #(
    .DEPTH (ORD_DEPTH),
    .WIDTH (1)
  ) u_ord_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_i       (bus_io.ord_wr),
    .wdata_i    (bus_io.ord_src),
    .rd_i       (ord_pop),
    .rdata_o    (ord_head),
    .empty_o    (ord_empty),
    .full_o     (ord_full),
    .used_o     (ord_used),
    .overflow_o (ord_ovf)
  );

  // The grant is held for the whole TLV; only the granted source's eot releases it.
  always_comb begin
    state_d = state_q;
    ord_pop = 1'b0;
    pt_rd   = 1'b0;
    lz_rd   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ord_empty) begin
          ord_pop = 1'b1;
          state_d = (be_ob_src_e'(ord_head[0]) == BE_SRC_LZ) ? LZ_XFER : PT_XFER;
        end
      end
      PT_XFER: begin
        pt_rd = !bus_io.pt_empty && !bus_io.ob_afull;
        if (pt_rd && bus_io.pt_tlv.eot) state_d = IDLE;
      end
      LZ_XFER: begin
        lz_rd = !bus_io.lz_empty && !bus_io.ob_afull;
        if (lz_rd && bus_io.lz_tlv.eot) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ob_tlv_d = ob_tlv_q;
    if (pt_rd)      ob_tlv_d = bus_io.pt_tlv;
    else if (lz_rd) ob_tlv_d = bus_io.lz_tlv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ovf_q    <= 1'b0;
      ob_wr_q  <= 1'b0;
      ob_tlv_q <= '0;
    end else begin
      state_q  <= state_d;
      ovf_q    <= ovf_q | ord_ovf;
      ob_wr_q  <= pt_rd | lz_rd;
      ob_tlv_q <= ob_tlv_d;
    end
  end

  assign bus_io.pt_rd        = pt_rd;
  assign bus_io.lz_rd        = lz_rd;
  assign bus_io.ob_wr        = ob_wr_q;
  assign bus_io.ob_tlv       = ob_tlv_q;
  assign bus_io.ord_afull    = (ord_used >= AfullLvl);
  assign bus_io.ord_overflow = ovf_q;
  assign bus_io.busy         = (state_q != IDLE) || ob_wr_q;

`ifdef CR_XP10_DECOMP_BE_OB_STATS_EN
  cr_xp10_decomp_be_ob_stats u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .pt_eot_i         (pt_rd && bus_io.pt_tlv.eot),
    .lz_eot_i         (lz_rd && bus_io.lz_tlv.eot),
    .stall_i          ((state_q != IDLE) && !pt_rd && !lz_rd),
    .stat_pt_tlvs_o   (bus_io.stat_pt_tlvs),
    .stat_lz_tlvs_o   (bus_io.stat_lz_tlvs),
    .stat_stall_cyc_o (bus_io.stat_stall_cyc)
  );
`endif

endmodule

// File: doc/cr_xp10_decomp_be_ob_arb.md
Name: cr_xp10_decomp_be_ob_arb

Overview:
- Output scheduler for the XP10 decompressor back end.
- Merges two TLV sources onto the single engine output TLV write port:
  - the pass-through TLV FIFO (PT);
  - the decompressed-data TLV FIFO (LZ).
- Grants are TLV-atomic (sot..eot). Grant order comes from an internal order queue, which the front-end header parser pushes once per TLV it routes, so TLV order on the output matches input order.

Parameters:
- ORD_DEPTH, 16: order-queue entries (power of 2, minimum 4).
- ORD_AFULL_LVL, 12: ord_afull asserts when used slots >= this value.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- ord_wr  input  1  push one order entry.
- ord_src  input  1  entry source: 0 = PT, 1 = LZ.
- ord_afull  output  1  order queue almost full (used >= ORD_AFULL_LVL).
- ord_overflow  output  1  sticky: push attempted while the queue was full.
- pt_empty  input  1  PT FIFO empty.
- pt_tlv  input  $bits(tlvp_if_bus_t)  PT FIFO show-ahead read data.
- pt_rd  output  1  PT FIFO read enable.
- lz_empty  input  1  LZ FIFO empty.
- lz_tlv  input  $bits(tlvp_if_bus_t)  LZ FIFO show-ahead read data.
- lz_rd  output  1  LZ FIFO read enable.
- ob_afull  input  1  downstream almost full (at least 2 free slots remain when it asserts).
- ob_wr  output  1  output write strobe.
- ob_tlv  output  $bits(tlvp_if_bus_t)  output TLV word.
- busy  output  1  state != IDLE, or ob_wr pending.

Behaviour:
- Reset values:
  - all outputs 0;
  - state = IDLE;
  - order queue empty; ord_overflow = 0.
- Order queue:
  - Synchronous FIFO with no write-to-read bypass: an entry pushed in cycle N is poppable in cycle N+1 at the earliest.
  - A push while full is dropped and sets ord_overflow; only reset clears it.
  - Push and pop in the same cycle while full: the pop frees a slot first, so the push is accepted.
- States:
  - IDLE:
    - If the queue is non-empty, pop the head, latch src, and go to PT_XFER or LZ_XFER in the next cycle.
    - Nothing is read in IDLE.
  - PT_XFER: pt_rd = !pt_empty && !ob_afull. When pt_rd is high and pt_tlv.eot = 1, go to IDLE.
  - LZ_XFER: same rule using the lz_* signals.
- Read enables:
  - pt_rd and lz_rd are combinational and mutually exclusive.
  - Neither is asserted outside its XFER state.
- Output path:
  - ob_wr and ob_tlv are registered: ob_wr(N+1) = pt_rd(N) | lz_rd(N).
  - ob_tlv(N+1) is the granted source's data word from cycle N, unmodified.
  - ob_tlv holds its value when ob_wr = 0.
- Throughput:
  - One word per cycle inside a TLV.
  - One dead cycle (IDLE) between TLVs.
  - Latency from the first poppable queue entry to the first ob_wr is 2 cycles.
- Stalls:
  - A source that empties mid-TLV holds the grant; no other source is serviced until that source delivers eot.
  - ob_afull stalls reads only; words already read are always written.
- Single-word TLV (sot = eot = 1): valid; return to IDLE after one read.
- Reset mid-TLV: asynchronous return to IDLE. The partial TLV is abandoned; upstream FIFOs are reset by the same rst_n.

Optional Feature:
- Macro: CR_XP10_DECOMP_BE_OB_STATS_EN.
- Defined:
  - Adds outputs stat_pt_tlvs[31:0], stat_lz_tlvs[31:0] and stat_stall_cyc[31:0].
  - stat_pt_tlvs and stat_lz_tlvs increment on each eot word read from the respective source.
  - stat_stall_cyc increments for each XFER cycle in which no read occurs.
  - All three counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- cr_xp10_decompPKG gets:
  - typedef enum logic[1:0] be_ob_arb_st_e {IDLE, PT_XFER, LZ_XFER};
  - typedef enum logic be_ob_src_e {BE_SRC_PT = 1'b0, BE_SRC_LZ = 1'b1};
  - localparam BE_OB_ORD_DEPTH = 16.
- The order queue is an nx_fifo instance (WIDTH 1).
- One sub-module: cr_xp10_decomp_be_ob_stats, the saturating counters, instantiated only under the macro.

Test Plan:
- Single PT TLV: push ord_src = 0, PT holds 3 words (sot, -, eot).
  - pt_rd in cycles 2-4 after the push; ob_wr in cycles 3-5; data identical; lz_rd never asserted.
- Interleaved order: push PT, LZ, PT; the LZ TLV is 5 words with both FIFOs pre-filled.
  - Output sequence is PT, LZ, PT with exactly one idle cycle between TLVs.
- Mid-TLV starvation: LZ grant with the LZ FIFO empty for 4 cycles after word 2; PT has data queued.
  - No pt_rd until LZ eot; the LZ TLV is delivered intact.
- Backpressure: ob_afull held high for 6 cycles mid-TLV.
  - No reads during the hold; the word in flight is still written; transfer resumes with no loss or duplication.
- Order overflow: push 17 entries with ORD_DEPTH = 16 and no pops.
  - ord_afull from the 12th push; ord_overflow = 1 after the 17th, and stays 1 until reset.
- Reset during the 2nd word of a 4-word TLV:
  - All outputs 0 immediately; state IDLE; a new TLV after reset is forwarded correctly.
  - With CR_XP10_DECOMP_BE_OB_STATS_EN defined, counters read 0.
